// File: rtl/fc3_bias_reader.sv
// -----------------------------------------------------------------------------
// fc3_bias_reader
//
// Adds a per-lane bias, fetched from a synchronous bias ROM, to a stream of
// accumulator batches. One pass walks ROM words 0..N_BATCH-1. For each word
// the block reads the ROM, waits for one accumulator batch, adds the two
// vectors lane by lane with saturation, and holds the result until the
// downstream side accepts it.
//
// Ports
//   clk        rising-edge clock
//   rstn       synchronous reset, ACTIVE-HIGH despite the name
//   start      one-cycle pulse that starts a pass (only honoured when idle)
//   acc_valid  / acc_ready / acc_data   accumulator batch handshake and lanes
//   rom_aa     bias ROM address
//   rom_cena   bias ROM read enable, active-low
//   rom_qa     bias ROM data (one cycle after the read)
//   out_valid  / out_ready / out_data   biased batch handshake and lanes
//   out_last   marks the final batch of a pass
//   busy       high whenever a pass is in progress
//   done       high on the handshake cycle of the final batch
//
// Lane 0 always occupies the most-significant field of every packed vector.
// -----------------------------------------------------------------------------
module fc3_bias_reader #(
   parameter int N_LANE  = 5,
   parameter int N_BATCH = 5,
   parameter int WB      = 34,
   parameter int WACC    = 34,
   parameter int WA      = 3
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   acc_valid,
   output logic                   acc_ready,
   input  logic [N_LANE*WACC-1:0] acc_data,
   output logic [WA-1:0]          rom_aa,
   output logic                   rom_cena,
   input  logic [N_LANE*WB-1:0]   rom_qa,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N_LANE*WACC-1:0] out_data,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done
);

   // One guard bit above the wider operand makes the add exact.
   localparam int            WS     = ((WACC > WB) ? WACC : WB) + 1;
   localparam logic [WA-1:0] LAST_B = WA'(N_BATCH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ACC,
      S_OUT
   } state_t;

   state_t                 state;
   logic [WA-1:0]          b;
   logic [N_LANE*WB-1:0]   bias_reg;
   logic [N_LANE*WACC-1:0] sum_data;

   // -------------------------------------------------------------------------
   // Per-lane saturating add
   // -------------------------------------------------------------------------
   for (genvar k = 0; k < N_LANE; k++) begin : g_lane
      logic [WACC-1:0]   a;
      logic [WB-1:0]     c;
      logic [WS-1:0]     s;
      logic [WS-WACC:0]  top;
      logic [WACC-1:0]   sat;

      assign a = acc_data[(N_LANE-1-k)*WACC +: WACC];
      assign c = bias_reg[(N_LANE-1-k)*WB +: WB];
      assign s = {{(WS-WACC){a[WACC-1]}}, a} + {{(WS-WB){c[WB-1]}}, c};

      // The sum fits in WACC signed bits exactly when every bit from the
      // top of the sum down to the WACC sign position agrees.
      assign top = s[WS-1:WACC-1];
      assign sat = ((&top) || !(|top)) ? s[WACC-1:0] :
                   s[WS-1]             ? {1'b1, {(WACC-1){1'b0}}} :
                                         {1'b0, {(WACC-1){1'b1}}};

      assign sum_data[(N_LANE-1-k)*WACC +: WACC] = sat;
   end

   // done is decoded from the handshake itself so that it coincides with the
   // last OUT cycle; a start seen in that cycle therefore lands in OUT and is
   // ignored. Reset suppresses it because reset wins over the handshake.
   assign done = (state == S_OUT) && out_ready && (b == LAST_B) && !rstn;

   // -------------------------------------------------------------------------
   // Control FSM with registered outputs
   // -------------------------------------------------------------------------
   // NOTE: every register in this block is updated with <= so all of them
   // see the pre-edge values of each other, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state     <= S_IDLE;
         b         <= '0;
         bias_reg  <= '0;
         rom_aa    <= '0;
         rom_cena  <= 1'b1;
         acc_ready <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  b        <= '0;
                  rom_aa   <= '0;
                  rom_cena <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_FETCH;
               end
            end

            // The ROM samples address/enable at the end of this cycle.
            S_FETCH: begin
               rom_cena <= 1'b1;
               state    <= S_WAIT;
            end

            // ROM output is valid during this cycle; keep a private copy so
            // the ROM may be shared or reused while the batch is pending.
            S_WAIT: begin
               bias_reg  <= rom_qa;
               acc_ready <= 1'b1;
               state     <= S_ACC;
            end

            S_ACC: begin
               if (acc_valid) begin
                  out_data  <= sum_data;
                  out_last  <= (b == LAST_B);
                  out_valid <= 1'b1;
                  acc_ready <= 1'b0;
                  state     <= S_OUT;
               end
            end

            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (b == LAST_B) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     b        <= b + 1'b1;
                     rom_aa   <= b + 1'b1;
                     rom_cena <= 1'b0;
                     state    <= S_FETCH;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fc3_bias_reader.md
FC3_BIAS_READER -- requirements
Module: fc3_bias_reader

Interface
REQ-001 Parameter N_LANE, default 5: bias lanes per ROM word (one batch).
REQ-002 Parameter N_BATCH, default 5: batches per pass; ROM addresses 0..N_BATCH-1.
REQ-003 Parameter WB, default 34: signed bias lane width.
REQ-004 Parameter WACC, default 34: signed accumulator and output lane width.
REQ-005 Parameter WA, default 3: ROM address width, sized so that 2^WA >= N_BATCH.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rstn  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse that begins a pass; sampled only in IDLE.
REQ-009 acc_valid  in  1  accumulator batch valid.
REQ-010 acc_ready  out  1  block accepts an accumulator batch.
REQ-011 acc_data  in  N_LANE*WACC  accumulator lanes; lane 0 in the most-significant field.
REQ-012 rom_aa  out  WA  bias ROM address.
REQ-013 rom_cena  out  1  bias ROM read enable, active-low.
REQ-014 rom_qa  in  N_LANE*WB  bias ROM data, registered in the ROM with 1-cycle latency; lane 0 in the MSB field.
REQ-015 out_valid  out  1  biased batch valid.
REQ-016 out_ready  in  1  downstream accepts the batch.
REQ-017 out_data  out  N_LANE*WACC  biased lanes; lane 0 in the MSB field.
REQ-018 out_last  out  1  high with out_valid on batch N_BATCH-1.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse when a pass completes.

Function
REQ-021 FSM states: IDLE, FETCH, WAIT, ACC, OUT; batch counter b runs 0..N_BATCH-1.
REQ-022 IDLE: when start=1, clear b to 0 and go to FETCH on the next cycle; otherwise stay in IDLE.
REQ-023 FETCH (exactly one cycle): drive rom_cena=0 and rom_aa=b, then go to WAIT.
REQ-024 In all other states, drive rom_cena=1; rom_aa holds its last value.
REQ-025 WAIT (exactly one cycle): capture rom_qa into bias_reg at the end of the cycle, then go to ACC.
REQ-026 ACC: drive acc_ready=1; on acc_valid=1, register out_data, set out_valid=1, and go to OUT.
REQ-027 acc_ready=0 in every state other than ACC.
REQ-028 Per-lane result: out lane k = sat_WACC(acc lane k + sign-extended bias lane k).
REQ-029 Sum width: the add is performed at max(WACC,WB)+1 bits.
REQ-030 Saturation: results above the WACC signed range clamp to 2^(WACC-1)-1; results below clamp to -2^(WACC-1).
REQ-031 OUT: out_valid=1; out_data and out_last are held stable until out_ready=1.
REQ-032 On the OUT handshake with b<N_BATCH-1: increment b and go to FETCH.
REQ-033 On the OUT handshake with b=N_BATCH-1: go to IDLE and pulse done=1 for one cycle.
REQ-034 out_valid falls on the cycle after the OUT handshake.
REQ-035 Minimum per-batch latency is 4 cycles from FETCH to out_valid, with acc_valid and out_ready held high.
REQ-036 start asserted in any non-IDLE state is ignored.
REQ-037 acc_valid outside ACC is ignored; no data is consumed.
REQ-038 Data is consumed only in ACC, and only when acc_valid=1.
REQ-039 done and start in the same cycle: start is ignored (state is still OUT); a new start is needed in IDLE.
REQ-040 The address sequence within a pass is strictly 0,1,...,N_BATCH-1, with no wrap and no repeat.

Reset
REQ-041 rstn=1 forces, at the next clock edge: state=IDLE, b=0, bias_reg=0, rom_aa=0, rom_cena=1, acc_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
REQ-042 rstn asserted mid-pass aborts the pass; no done pulse is produced and the partial pass is not resumed.
REQ-043 Reset has priority over start and over both handshakes in the same cycle.

Verification
REQ-044 Single pass with a ROM model of 25 known values, acc_data=0 every batch, out_ready=1 -> five beats equal to ROM words 0..4, out_last only on beat 5, done once, rom_aa sequence 0,1,2,3,4.
REQ-045 Saturation (lane 0): acc=2^33-10 with bias=+100 -> 2^33-1; acc=-2^33+5 with bias=-50 -> -2^33.
REQ-046 Backpressure: out_ready=0 for 7 cycles in batch 2 -> out_data stable throughout, no ROM read, acc_ready=0, and b advances only after the handshake.
REQ-047 acc_valid low for 3 cycles in ACC -> block waits; output equals the later acc_data plus the bias.
REQ-048 rstn pulsed during WAIT of batch 3 -> all outputs at reset values next cycle; a new start restarts from rom_aa=0.
REQ-049 start held high for a whole pass -> exactly one pass while busy; a second pass begins only after IDLE is reached.
